// File: rtl/pdp8_defs.sv
// rtl/pdp8_defs.sv - shared PDP-8 operate-group encodings and op decode
package pdp8_defs;

  localparam int DEF_AC_WIDTH = 12;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_RAL  = 3'd1;
  localparam logic [2:0] OP_RAR  = 3'd2;
  localparam logic [2:0] OP_RTL  = 3'd3;
  localparam logic [2:0] OP_RTR  = 3'd4;
  localparam logic [2:0] OP_BSW  = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC1 = 2'd1;
  localparam logic [1:0] ST_EXEC2 = 2'd2;

  // Conflicting rotate requests (ral & rar) fall through to a plain pass-through.
  function automatic logic [2:0] decode_op(input logic ral, input logic rar, input logic twice);
    logic [2:0] op;
    op = OP_NONE;
    if (ral && !rar)
      op = twice ? OP_RTL : OP_RAL;
    else if (rar && !ral)
      op = twice ? OP_RTR : OP_RAR;
    else if (!ral && !rar && twice)
      op = OP_BSW;
    return op;
  endfunction

endpackage

// File: rtl/ck_edge.sv
// rtl/ck_edge.sv - registered rising-edge detector for the shared ck strobe
module ck_edge (
  input  logic clk,
  input  logic reset,
  input  logic ck,
  output logic rise
);

  logic ck_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ck_q <= 1'b0;
    else        ck_q <= ck;
  end

  assign rise = ck & ~ck_q;

endmodule

// File: rtl/rotater.sv
// rtl/rotater.sv - PDP-8 rotate/byte-swap stage between Link and AC stages
module rotater
  import pdp8_defs::*;
#(
  parameter int AC_WIDTH = DEF_AC_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ck,
  input  logic                L_IN,
  input  logic [AC_WIDTH-1:0] AC_IN,
  input  logic                ral,
  input  logic                rar,
  input  logic                twice,
  output logic                L_OUT,
  output logic [AC_WIDTH-1:0] AC_OUT,
  output logic                FORCE,
  output logic                BUSY,
  output logic                DONE,
  output logic                OVERRUN
);

  localparam int HALF = AC_WIDTH / 2;

  logic                rise;
  logic [AC_WIDTH:0]   s_q, s_d;
  logic [1:0]          state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                force_q, force_d;
  logic                overrun_q, overrun_d;

  ck_edge u_ck_edge (
    .clk   (clk),
    .reset (reset),
    .ck    (ck),
    .rise  (rise)
  );

  // S is {L, AC}; one rotate moves every bit of the 13-bit ring by one place.
  function automatic logic [AC_WIDTH:0] step_fn(input logic [AC_WIDTH:0] s, input logic [2:0] op);
    logic [AC_WIDTH:0] r;
    r = s;
    case (op)
      OP_RAL, OP_RTL: r = {s[AC_WIDTH-1:0], s[AC_WIDTH]};
      OP_RAR, OP_RTR: r = {s[0], s[AC_WIDTH], s[AC_WIDTH-1:1]};
      OP_BSW:         r = {s[AC_WIDTH], s[HALF-1:0], s[AC_WIDTH-1:HALF]};
      default:        r = s;
    endcase
    return r;
  endfunction

  always_comb begin
    s_d       = s_q;
    state_d   = state_q;
    op_d      = op_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    force_d   = 1'b0;
    overrun_d = rise & busy_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          s_d     = {L_IN, AC_IN};
          op_d    = decode_op(ral, rar, twice);
          busy_d  = 1'b1;
          state_d = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        s_d = step_fn(s_q, op_q);
        if (op_q == OP_RTL || op_q == OP_RTR) begin
          state_d = ST_EXEC2;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          force_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EXEC2: begin
        s_d     = step_fn(s_q, op_q);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        force_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q       <= '0;
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      force_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      state_q   <= state_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      force_q   <= force_d;
      overrun_q <= overrun_d;
    end
  end

  assign L_OUT   = s_q[AC_WIDTH];
  assign AC_OUT  = s_q[AC_WIDTH-1:0];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign FORCE   = force_q;
  assign OVERRUN = overrun_q;

endmodule
